// File: rtl/mc_path_gen.sv
// mc_path_gen: generates N multiplicative random-walk price paths from an LFSR,
// then streams them last day first, all paths per day, in path order.
module mc_path_gen #(
  parameter int N   = 128,
  parameter int DAY = 8,
  parameter int W   = 12
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           s0,
  input  logic [11:0]            drift,
  input  logic [11:0]            vol,
  input  logic [31:0]            seed,
  output logic                   busy,
  output logic                   path_valid,
  input  logic                   path_ready,
  output logic [W-1:0]           path_data,
  output logic [$clog2(DAY)-1:0] path_day,
  output logic [$clog2(N)-1:0]   path_idx,
  output logic                   path_last,
  output logic                   done
);
  localparam int PW = $clog2(N);
  localparam int DW = $clog2(DAY);
  localparam logic signed [W+2:0] SMAX = (W+3)'((1 << W) - 1);
  typedef enum logic [1:0] {IDLE, GEN, STREAM} state_t;
  state_t st, nxt;
  logic [W-1:0] mem [N*DAY];
  logic [31:0] lfsr;
  logic [PW-1:0] p, si;
  logic [DW-1:0] d, sd;
  logic [W-1:0] s0_q, cur, s, snext;
  logic signed [11:0] drift_q, r;
  logic [11:0] vol_q;
  logic [9:0] sum;
  logic signed [10:0] z;
  logic signed [23:0] vz;
  logic signed [14:0] rw;
  logic signed [W+12:0] sr;
  logic signed [W+2:0] sn;
  logic gen_end, fin;
  assign sum = {2'b0, lfsr[7:0]} + {2'b0, lfsr[15:8]} + {2'b0, lfsr[23:16]} + {2'b0, lfsr[31:24]};
  assign z = $signed({1'b0, sum}) - 11'sd510;
  assign vz = $signed({12'b0, vol_q}) * 24'(z);
  assign rw = 15'(drift_q) + 15'(vz >>> 8);
  assign r = rw > 15'sd2047 ? 12'sd2047 : rw < -15'sd2048 ? 12'sh800 : rw[11:0];
  // day 0 of every path is s0 itself, so it is never stored in the memory
  assign s = (d == DW'(1)) ? s0_q : cur;
  assign sr = $signed({13'b0, s}) * (W+13)'(r);
  assign sn = $signed({3'b0, s}) + (W+3)'(sr >>> 11);
  assign snext = sn < 0 ? '0 : sn > SMAX ? '1 : sn[W-1:0];
  assign gen_end = (p == PW'(N-1)) && (d == DW'(DAY-1));
  assign fin = path_valid && path_ready && path_last;
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_comb
    nxt = st == IDLE ? (start ? GEN : IDLE) : st == GEN ? (gen_end ? STREAM : GEN) : (fin ? IDLE : STREAM);
  always_comb
    busy = st != IDLE;
  always_ff @(posedge clk)
    if (st == GEN) mem[{d, p}] <= snext;
  always_ff @(posedge clk)
    if (rst) begin
      lfsr       <= 32'h1;
      p          <= '0;
      d          <= '0;
      si         <= '0;
      sd         <= '0;
      cur        <= '0;
      s0_q       <= '0;
      drift_q    <= '0;
      vol_q      <= '0;
      path_valid <= 1'b0;
      path_data  <= '0;
      path_day   <= '0;
      path_idx   <= '0;
      path_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= fin;
      if (st == IDLE && start) begin
        s0_q    <= s0;
        drift_q <= drift;
        vol_q   <= vol;
        lfsr    <= seed == 32'h0 ? 32'h1 : seed;
        p       <= '0;
        d       <= DW'(1);
        sd      <= DW'(DAY-1);
        si      <= '0;
      end
      if (st == GEN) begin
        cur  <= snext;
        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        d    <= d == DW'(DAY-1) ? DW'(1) : d + DW'(1);
        p    <= d == DW'(DAY-1) ? p + PW'(1) : p;
      end
      if (st == STREAM) begin
        if (fin) begin
          path_valid <= 1'b0;
          path_last  <= 1'b0;
        end else if (!path_valid || path_ready) begin
          path_valid <= 1'b1;
          path_data  <= sd == '0 ? s0_q : mem[{sd, si}];
          path_day   <= sd;
          path_idx   <= si;
          path_last  <= sd == '0 && si == PW'(N-1);
          si         <= si + PW'(1);
          sd         <= si == PW'(N-1) ? sd - DW'(1) : sd;
        end
      end
    end
endmodule

// File: tb/tb_mc_path_gen.sv
// tb_mc_path_gen: directed runs of mc_path_gen checked beat-by-beat against
// a plain-arithmetic model of the path recurrence.
module tb_mc_path_gen;
  localparam int N = 128, DAY = 8, W = 12;
  logic clk = 1'b0;
  logic rst, start, path_ready;
  logic [W-1:0] s0;
  logic [11:0] drift, vol;
  logic [31:0] seed;
  logic busy, path_valid, path_last, done;
  logic [W-1:0] path_data;
  logic [2:0] path_day;
  logic [6:0] path_idx;
  int tests = 0, fails = 0;
  logic [11:0] mdl [DAY][N];

  always #5 clk = ~clk;

  mc_path_gen #(.N(N), .DAY(DAY), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .s0(s0), .drift(drift), .vol(vol),
    .seed(seed), .busy(busy), .path_valid(path_valid), .path_ready(path_ready),
    .path_data(path_data), .path_day(path_day), .path_idx(path_idx),
    .path_last(path_last), .done(done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [11:0] a_s0, a_dr, a_vol, input logic [31:0] a_seed);
    logic [31:0] l;
    int s, z, r, dr;
    l = a_seed == 32'h0 ? 32'h1 : a_seed;
    dr = int'($signed(a_dr));
    for (int p = 0; p < N; p++) begin
      s = int'(a_s0);
      mdl[0][p] = a_s0;
      for (int d = 1; d < DAY; d++) begin
        z = int'(l[7:0]) + int'(l[15:8]) + int'(l[23:16]) + int'(l[31:24]) - 510;
        r = dr + ((int'(a_vol) * z) >>> 8);
        r = r > 2047 ? 2047 : r < -2048 ? -2048 : r;
        s = s + ((s * r) >>> 11);
        s = s < 0 ? 0 : s > 4095 ? 4095 : s;
        mdl[d][p] = 12'(s);
        l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      end
    end
  endtask

  task automatic run(input string nm, input logic [11:0] a_s0, a_dr, a_vol,
                     input logic [31:0] a_seed, input int pct, input int rst_at, input bit spur);
    int cyc, beats, guard, k, ed, ei;
    logic [23:0] snap;
    bit held;
    build(a_s0, a_dr, a_vol, a_seed);
    s0 = a_s0; drift = a_dr; vol = a_vol; seed = a_seed;
    path_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy"}, int'(busy), 1);
    cyc = 0;
    while (!path_valid && cyc < 2000) begin
      start = spur && cyc == 100;
      if (start) begin
        s0 = ~a_s0; drift = 12'h7ff; vol = 12'h123; seed = 32'h5555_0001;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " latency"}, cyc, N*(DAY-1)+1);
    beats = 0; guard = 0; held = 1'b0; snap = '0;
    while (beats < N*DAY && guard < 20000) begin
      path_ready = $urandom_range(99) < pct;
      if (rst_at >= 0 && beats == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({nm, " rst valid"}, int'(path_valid), 0);
        chk({nm, " rst busy"}, int'(busy), 0);
        chk({nm, " rst done"}, int'(done), 0);
        return;
      end
      if (held) chk($sformatf("%s hold beat%0d", nm, beats),
                    int'({path_valid, path_data, path_day, path_idx, path_last}), int'(snap));
      held = path_valid && !path_ready;
      snap = {path_valid, path_data, path_day, path_idx, path_last};
      if (path_valid && path_ready) begin
        k = beats;
        ed = DAY - 1 - k / N;
        ei = k % N;
        chk($sformatf("%s beat%0d data", nm, k), int'(path_data), int'(mdl[ed][ei]));
        chk($sformatf("%s beat%0d day", nm, k), int'(path_day), ed);
        chk($sformatf("%s beat%0d idx", nm, k), int'(path_idx), ei);
        chk($sformatf("%s beat%0d last", nm, k), int'(path_last), int'(k == N*DAY-1));
        beats++;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk({nm, " beats"}, beats, N*DAY);
    if (pct >= 100) chk({nm, " cycles"}, guard, N*DAY);
    chk({nm, " end valid"}, int'(path_valid), 0);
    chk({nm, " end busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 1);
    @(posedge clk); #1;
    chk({nm, " done pulse"}, int'(done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; path_ready = 1'b0;
    s0 = '0; drift = '0; vol = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", int'(path_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset last", int'(path_last), 0);
    chk("reset data", int'(path_data), 0);
    chk("reset day", int'(path_day), 0);
    chk("reset idx", int'(path_idx), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run("flat",   12'd1000, 12'd0,    12'd0,    32'd1,       100, -1,  1'b0);
    run("drift",  12'd1024, 12'd256,  12'd0,    32'd5,       100, -1,  1'b0);
    run("sat",    12'd4000, 12'd2047, 12'd0,    32'd9,       100, -1,  1'b0);
    run("rand",   12'd2048, 12'd0,    12'd4095, 32'hACE1,    100, -1,  1'b0);
    run("bp",     12'd2048, 12'd0,    12'd4095, 32'hACE1,    50,  -1,  1'b0);
    run("spur",   12'd2048, 12'd0,    12'd4095, 32'hACE1,    100, -1,  1'b1);
    run("rstmid", 12'd1500, 12'hF80,  12'd3000, 32'h1234567, 70,  300, 1'b0);
    run("seed0",  12'd3000, 12'h040,  12'd2500, 32'h0,       60,  -1,  1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
